parking_gate_controller: RTL

Sequencer for the single barrier gate shared by the entry and exit lanes. It takes debounced entry-request, exit-request and car-passed levels, one per Debouncer output, and edge-detects and latches each request. It arbitrates between lanes, opens the gate for one car at a time, closes it on passage or timeout, and maintains the lot occupancy count against a fixed capacity.

---
 rtl/parking_pkg.sv | 26 ++
 rtl/parking_gate_controller_if.sv | 30 +++
 rtl/rise_detect.sv | 20 ++
 rtl/parking_gate_controller.sv | 137 +++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and default constants for the parking gate controller.
//   state_t : gate sequencer states
//   lane_t  : lane identifiers used for arbitration
package parking_pkg;

    localparam int unsigned DEF_CAPACITY     = 8;
    localparam int unsigned DEF_OPEN_CYCLES  = 40_000_000;
    localparam int unsigned DEF_GUARD_CYCLES = 4_000_000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_CLOSE = 2'd2
    } state_t;

    typedef enum logic {
        LANE_ENTRY = 1'b0,
        LANE_EXIT  = 1'b1
    } lane_t;

    // Larger of two cycle counts; sizes the shared open/guard timer.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/parking_gate_controller_if.sv
// Lane/gate signal bundle for the parking gate controller.
//   master : request source (drives entryReq, exitReq, carPassed)
//   slave  : controller (drives gateOpen, grants, denied, count, full, empty)
interface parking_gate_controller_if #(
    parameter int unsigned CAPACITY = parking_pkg::DEF_CAPACITY
);
    localparam int unsigned CW = $clog2(CAPACITY + 1);

    logic          entryReq;
    logic          exitReq;
    logic          carPassed;
    logic          gateOpen;
    logic          grantEntry;
    logic          grantExit;
    logic          denied;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    modport master (
        output entryReq, exitReq, carPassed,
        input  gateOpen, grantEntry, grantExit, denied, count, full, empty
    );

    modport slave (
        input  entryReq, exitReq, carPassed,
        output gateOpen, grantEntry, grantExit, denied, count, full, empty
    );

endinterface

// File: rtl/rise_detect.sv
// Rising-edge detector on a debounced level.
//   clk, reset (async active-low), in : level input
//   rise : high in the cycle where in is 1 and its registered previous value is 0
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev_q <= 1'b0;
        else        prev_q <= in;
    end

    assign rise = in & ~prev_q;

endmodule

// File: rtl/parking_gate_controller.sv
// Single-barrier gate sequencer shared by entry and exit lanes.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : lane requests in; gate command, grants, denied pulse, occupancy out
module parking_gate_controller
    import parking_pkg::*;
#(
    parameter int unsigned CAPACITY     = DEF_CAPACITY,
    parameter int unsigned OPEN_CYCLES  = DEF_OPEN_CYCLES,
    parameter int unsigned GUARD_CYCLES = DEF_GUARD_CYCLES
) (
    input  logic                        clk,
    input  logic                        reset,
    parking_gate_controller_if.slave    bus
);

    localparam int unsigned CW   = $clog2(CAPACITY + 1);
    localparam int unsigned TMAX = max_u(OPEN_CYCLES, GUARD_CYCLES);
    localparam int unsigned TW   = $clog2(TMAX + 1);

    state_t        state_q;
    lane_t         prio_q;        // lane that wins the next tie
    logic [TW-1:0] timer_q;
    logic [CW-1:0] count_q;
    logic          pend_entry_q;
    logic          pend_exit_q;
    logic          gate_open_q;
    logic          grant_entry_q;
    logic          grant_exit_q;
    logic          denied_q;

    logic entry_rise, exit_rise, car_rise;
    logic full_c, empty_c;
    logic entry_set_c, entry_deny_c, exit_set_c;

    rise_detect u_rise_entry (.clk(clk), .reset(reset), .in(bus.entryReq),  .rise(entry_rise));
    rise_detect u_rise_exit  (.clk(clk), .reset(reset), .in(bus.exitReq),   .rise(exit_rise));
    rise_detect u_rise_car   (.clk(clk), .reset(reset), .in(bus.carPassed), .rise(car_rise));

    assign full_c  = (count_q == CW'(CAPACITY));
    assign empty_c = (count_q == '0);

    // Request qualification against current occupancy.
    always_comb begin
        entry_set_c  = 1'b0;
        entry_deny_c = 1'b0;
        exit_set_c   = 1'b0;
        if (entry_rise) begin
            if (full_c) entry_deny_c = 1'b1;
            else        entry_set_c  = 1'b1;
        end
        if (exit_rise && !empty_c) exit_set_c = 1'b1;
    end

    // Sequencer: pending latches, arbitration, shared timer, occupancy.
    // A fresh rise in the grant cycle re-latches rather than being lost,
    // hence the flag clears write the set term instead of a constant 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            prio_q        <= LANE_EXIT;
            timer_q       <= '0;
            count_q       <= '0;
            pend_entry_q  <= 1'b0;
            pend_exit_q   <= 1'b0;
            gate_open_q   <= 1'b0;
            grant_entry_q <= 1'b0;
            grant_exit_q  <= 1'b0;
            denied_q      <= 1'b0;
        end else begin
            denied_q <= entry_deny_c;
            if (entry_set_c) pend_entry_q <= 1'b1;
            if (exit_set_c)  pend_exit_q  <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (pend_exit_q && (!pend_entry_q || prio_q == LANE_EXIT)) begin
                        pend_exit_q  <= exit_set_c;
                        prio_q       <= LANE_ENTRY;
                        grant_exit_q <= 1'b1;
                        gate_open_q  <= 1'b1;
                        timer_q      <= TW'(OPEN_CYCLES - 1);
                        state_q      <= ST_OPEN;
                    end else if (pend_entry_q) begin
                        pend_entry_q <= entry_set_c;
                        if (full_c) begin
                            denied_q <= 1'b1;
                        end else begin
                            prio_q        <= LANE_EXIT;
                            grant_entry_q <= 1'b1;
                            gate_open_q   <= 1'b1;
                            timer_q       <= TW'(OPEN_CYCLES - 1);
                            state_q       <= ST_OPEN;
                        end
                    end
                end

                ST_OPEN: begin
                    if (car_rise || timer_q == '0) begin
                        if (car_rise) begin
                            if (grant_entry_q) count_q <= count_q + CW'(1);
                            else               count_q <= count_q - CW'(1);
                        end
                        gate_open_q   <= 1'b0;
                        grant_entry_q <= 1'b0;
                        grant_exit_q  <= 1'b0;
                        timer_q       <= TW'(GUARD_CYCLES - 1);
                        state_q       <= ST_CLOSE;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end

                ST_CLOSE: begin
                    if (timer_q == '0) state_q <= ST_IDLE;
                    else               timer_q <= timer_q - TW'(1);
                end

                default: begin
                    state_q       <= ST_IDLE;
                    gate_open_q   <= 1'b0;
                    grant_entry_q <= 1'b0;
                    grant_exit_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gateOpen   = gate_open_q;
    assign bus.grantEntry = grant_entry_q;
    assign bus.grantExit  = grant_exit_q;
    assign bus.denied     = denied_q;
    assign bus.count      = count_q;
    assign bus.full       = full_c;
    assign bus.empty      = empty_c;

endmodule
